alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester request strobe; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 req_a  input  2N  signed operand a; requester i in bits [i*N +: N].
REQ-007 req_b  input  2N  signed operand b, same packing.
REQ-008 req_opcode  input  8  4-bit opcode per requester, bits [i*4 +: 4].
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_id  output  1  index of requester that owns the response.
REQ-012 rsp_result, rsp_remainder  output  N each  ALU result and remainder.
REQ-013 rsp_carry, rsp_zero, rsp_overflow  output  1 each  ALU flags.
REQ-014 rsp_err  output  1  opcode outside 0..9.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-017 IDLE: if any req_valid bit high, grant one requester, assert its req_ready combinationally that cycle, capture its a/b/opcode and id, go EXEC; else stay IDLE.
REQ-018 Request handshake completes only when req_valid[i] and req_ready[i] are both high; req_ready is low in EXEC and RESP.
REQ-019 Arbitration round-robin: 1-bit priority pointer selects preferred requester; if only one valid, it wins regardless of pointer.
REQ-020 Pointer updates to the non-granted index on each grant; unchanged when no grant.
REQ-021 EXEC: shared ALU evaluates captured operands; result, remainder, flags, err registered into response registers; go RESP.
REQ-022 RESP: rsp_valid high; all rsp_* outputs held stable until rsp_valid and rsp_ready both high; on that edge go IDLE and drop rsp_valid.
REQ-023 Latency: grant in cycle T gives rsp_valid in cycle T+2; minimum issue interval 3 cycles.
REQ-024 rsp_ready low in RESP: stay in RESP indefinitely, no new grant.
REQ-025 Opcode 10..15: rsp_err=1, rsp_result=0, rsp_remainder=0, all flags 0; response otherwise normal.
REQ-026 Divide/modulo by zero handled by ALU semantics; arbiter does not alter it; rsp_err=0.
REQ-027 Requester whose valid drops before grant is simply not served; no state retained.

Reset
REQ-028 rst asserted at any time: state to IDLE, pointer to 0, rsp_valid/req_ready/busy/rsp_* all 0, within the same cycle (asynchronous).
REQ-029 Transaction in EXEC or RESP during reset is discarded; no response issued after release.
REQ-030 First grant possible on first rising clk edge after rst deasserts.

Structure
REQ-031 Shared package holds FSM state encoding, opcode constants 0..9, OPCODE_MAX=9.
REQ-032 Exactly one sub-module: existing ALU_32_bit instantiated with N, fed only from capture registers.
REQ-033 No combinational path from rsp_ready to req_ready.

Verification
REQ-034 Single request: req0 a=2147483647, b=1, opcode 0 -> req_ready[0] at T, rsp_valid at T+2, rsp_id=0, rsp_overflow=1.
REQ-035 Contention: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1, one every 3 cycles.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=00, handshake completes on cycle rsp_ready rises.
REQ-037 Illegal opcode 4'b1100 from req1 -> rsp_err=1, rsp_result=0, rsp_id=1.
REQ-038 rst pulsed during EXEC -> rsp_valid stays 0, pointer 0; next simultaneous request grants requester 0.
REQ-039 Zero flag: a=5, b=5, opcode subtract -> rsp_result=0, rsp_zero=1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding and ALU opcodes.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;

  localparam logic [3:0] OPCODE_MAX = 4'd9;

endpackage

// File: rtl/ALU_32_bit.sv
// Combinational signed ALU shared by both requesters; illegal opcodes give err and all-zero outputs.
module ALU_32_bit
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic [3:0]          opcode,
  output logic [N-1:0]        result,
  output logic [N-1:0]        remainder,
  output logic                carry,
  output logic                zero,
  output logic                overflow,
  output logic                err
);

  localparam int unsigned SW = $clog2(N);

  logic [N:0]     sum_add;
  logic [N:0]     sum_sub;
  logic [2*N-1:0] prod;
  logic [SW-1:0]  shamt;
  logic           div_zero;
  logic           div_ovf;

  assign sum_add  = {1'b0, a} + {1'b0, b};
  assign sum_sub  = {1'b0, a} - {1'b0, b};
  // Sign-extended unsigned multiply: low 2N bits equal the signed product.
  assign prod     = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};
  assign shamt    = b[SW-1:0];
  assign div_zero = (b == '0);
  assign div_ovf  = (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);

  always_comb begin
    result    = '0;
    remainder = '0;
    carry     = 1'b0;
    overflow  = 1'b0;
    err       = 1'b0;
    case (opcode)
      OP_ADD: begin
        result   = sum_add[N-1:0];
        carry    = sum_add[N];
        overflow = (a[N-1] == b[N-1]) && (sum_add[N-1] != a[N-1]);
      end
      OP_SUB: begin
        result   = sum_sub[N-1:0];
        carry    = sum_sub[N];
        overflow = (a[N-1] != b[N-1]) && (sum_sub[N-1] != a[N-1]);
      end
      OP_MUL: begin
        result    = prod[N-1:0];
        remainder = prod[2*N-1:N];
        overflow  = (prod[2*N-1:N] != {N{prod[N-1]}});
      end
      OP_DIV: begin
        // Divide by zero yields all-ones quotient and the dividend as remainder.
        if (div_zero) begin
          result    = '1;
          remainder = a;
        end else if (div_ovf) begin
          result   = a;
          overflow = 1'b1;
        end else begin
          result    = a / b;
          remainder = a % b;
        end
      end
      OP_MOD: begin
        if (div_zero) begin
          result = a;
        end else if (!div_ovf) begin
          result = a % b;
        end
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRA:  result = a >>> shamt;
      default: err = 1'b1;
    endcase
    zero = !err && (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting one of two requesters access to a shared ALU,
// with an IDLE/EXEC/RESP handshake and registered response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [7:0]     req_opcode,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic [N-1:0]   rsp_remainder,
  output logic           rsp_carry,
  output logic           rsp_zero,
  output logic           rsp_overflow,
  output logic           rsp_err,
  output logic           busy
);

  state_e       state_q, state_d;
  logic         ptr_q;
  logic         grant_id;
  logic         grant_en;
  logic [N-1:0] cap_a_q, cap_b_q;
  logic [3:0]   cap_op_q;
  logic         cap_id_q;

  logic [N-1:0] alu_result, alu_remainder;
  logic         alu_carry, alu_zero, alu_overflow, alu_err;

  ALU_32_bit #(
    .N(N)
  ) u_alu (
    .a        (cap_a_q),
    .b        (cap_b_q),
    .opcode   (cap_op_q),
    .result   (alu_result),
    .remainder(alu_remainder),
    .carry    (alu_carry),
    .zero     (alu_zero),
    .overflow (alu_overflow),
    .err      (alu_err)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    grant_en  = 1'b0;
    // Pointer only matters under contention; a lone requester always wins.
    grant_id  = (&req_valid) ? ptr_q : req_valid[1];
    unique case (state_q)
      StIdle: begin
        // rst gates the grant so req_ready is low for the whole reset window.
        if ((|req_valid) && !rst) begin
          grant_en            = 1'b1;
          req_ready[grant_id] = 1'b1;
          state_d             = StExec;
        end
      end
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= 1'b0;
      cap_a_q       <= '0;
      cap_b_q       <= '0;
      cap_op_q      <= '0;
      cap_id_q      <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      rsp_carry     <= 1'b0;
      rsp_zero      <= 1'b0;
      rsp_overflow  <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        ptr_q    <= ~grant_id;
        cap_a_q  <= grant_id ? req_a[2*N-1:N] : req_a[N-1:0];
        cap_b_q  <= grant_id ? req_b[2*N-1:N] : req_b[N-1:0];
        cap_op_q <= grant_id ? req_opcode[7:4] : req_opcode[3:0];
        cap_id_q <= grant_id;
      end
      if (state_q == StExec) begin
        rsp_id        <= cap_id_q;
        rsp_result    <= alu_result;
        rsp_remainder <= alu_remainder;
        rsp_carry     <= alu_carry;
        rsp_zero      <= alu_zero;
        rsp_overflow  <= alu_overflow;
        rsp_err       <= alu_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter: a transaction-level model predicts grants and responses.
module tb_alu_arbiter;

  localparam int unsigned N = 32;
  localparam longint MAXI = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MINI = 64'shFFFF_FFFF_8000_0000;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready;
  logic [2*N-1:0] req_a, req_b;
  logic [7:0]     req_opcode;
  logic           rsp_valid, rsp_ready, rsp_id;
  logic [N-1:0]   rsp_result, rsp_remainder;
  logic           rsp_carry, rsp_zero, rsp_overflow, rsp_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .N(N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_opcode   (req_opcode),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_remainder(rsp_remainder),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] result;
    logic [31:0] rem;
    logic        carry;
    logic        zero;
    logic        ovf;
    logic        err;
    logic        id;
    int          ready_at;
  } exp_t;

  typedef struct {
    bit id;
    int cyc;
  } grant_t;

  // Integer-arithmetic reference for the ALU.
  function automatic exp_t alu_ref(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    exp_t   e;
    longint sa, sb, ua, ub, r;
    e.result = '0; e.rem = '0; e.carry = 0; e.ovf = 0; e.err = 0; e.id = 0; e.ready_at = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd0: begin
        r = ua + ub; e.result = r[31:0]; e.carry = r[32];
        e.ovf = (sa + sb > MAXI) || (sa + sb < MINI);
      end
      4'd1: begin
        r = ua - ub; e.result = r[31:0]; e.carry = (ua < ub);
        e.ovf = (sa - sb > MAXI) || (sa - sb < MINI);
      end
      4'd2: begin
        r = sa * sb; e.result = r[31:0]; e.rem = r[63:32];
        e.ovf = (r > MAXI) || (r < MINI);
      end
      4'd3: begin
        if (sb == 0) begin
          e.result = 32'hFFFF_FFFF; e.rem = a;
        end else if (sa == MINI && sb == -1) begin
          e.result = a; e.ovf = 1;
        end else begin
          r = sa / sb; e.result = r[31:0];
          r = sa % sb; e.rem = r[31:0];
        end
      end
      4'd4: begin
        if (sb == 0) e.result = a;
        else if (!(sa == MINI && sb == -1)) begin
          r = sa % sb; e.result = r[31:0];
        end
      end
      4'd5: e.result = a & b;
      4'd6: e.result = a | b;
      4'd7: e.result = a ^ b;
      4'd8: e.result = a << b[4:0];
      4'd9: begin
        r = sa >>> b[4:0]; e.result = r[31:0];
      end
      default: e.err = 1;
    endcase
    e.zero = !e.err && (e.result == 0);
    return e;
  endfunction

  // Reference model, evaluated on the falling edge with inputs already settled.
  exp_t   pend;
  bit     pend_v = 0;
  bit     ptr = 0;
  int     cyc = 0;
  int     mw;
  grant_t glog[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check_eq("rst_req_ready", req_ready, 2'b00);
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      pend_v = 0;
      ptr    = 0;
    end else begin
      check_eq("busy", busy, pend_v);
      if (!pend_v) begin
        check_eq("idle_rsp_valid", rsp_valid, 1'b0);
        if (req_valid != 2'b00) begin
          mw = (req_valid == 2'b11) ? int'(ptr) : int'(req_valid[1]);
          check_eq("grant", req_ready, 2'b01 << mw);
          pend          = alu_ref(req_opcode[mw*4 +: 4], req_a[mw*N +: N], req_b[mw*N +: N]);
          pend.id       = mw[0];
          pend.ready_at = cyc + 2;
          pend_v        = 1;
          ptr           = ~mw[0];
          glog.push_back('{id: mw[0], cyc: cyc});
        end else begin
          check_eq("no_grant", req_ready, 2'b00);
        end
      end else begin
        check_eq("ready_while_busy", req_ready, 2'b00);
        if (cyc >= pend.ready_at) begin
          check_eq("rsp_valid", rsp_valid, 1'b1);
          check_eq("rsp_id", rsp_id, pend.id);
          check_eq("rsp_result", rsp_result, pend.result);
          check_eq("rsp_remainder", rsp_remainder, pend.rem);
          check_eq("rsp_carry", rsp_carry, pend.carry);
          check_eq("rsp_zero", rsp_zero, pend.zero);
          check_eq("rsp_overflow", rsp_overflow, pend.ovf);
          check_eq("rsp_err", rsp_err, pend.err);
          if (rsp_ready) pend_v = 0;
        end else begin
          check_eq("exec_rsp_valid", rsp_valid, 1'b0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    req_a[i*N +: N]      = a;
    req_b[i*N +: N]      = b;
    req_opcode[i*4 +: 4] = op;
  endtask

  // Waits for rsp_valid on falling edges; lat is the edge count, 99 on timeout.
  task automatic wait_rsp(output int lat);
    lat = 99;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  int          lat;
  logic [31:0] snap_res, snap_rem;
  logic [3:0]  snap_flags;

  initial begin
    rst = 1; req_valid = 0; req_a = '0; req_b = '0; req_opcode = '0; rsp_ready = 1;
    repeat (2) step();

    // Single request with signed overflow; released straight out of reset.
    set_req(0, 32'h7FFF_FFFF, 32'd1, 4'd0);
    req_valid = 2'b01;
    rst = 0;
    step();
    req_valid = 2'b00;
    wait_rsp(lat);
    check_eq("single_latency", lat, 2);
    check_eq("single_id", rsp_id, 1'b0);
    check_eq("single_ovf", rsp_overflow, 1'b1);
    check_eq("single_result", rsp_result, 32'h8000_0000);
    step();

    // Contention right after reset: alternate 0,1,0,1 every 3 cycles.
    rst = 1;
    set_req(0, 32'd10, 32'd3, 4'd2);
    set_req(1, 32'd7, 32'd9, 4'd1);
    req_valid = 2'b11;
    repeat (2) step();
    glog.delete();
    rst = 0;
    repeat (12) step();
    req_valid = 2'b00;
    repeat (4) step();
    check_eq("contend_count", glog.size(), 4);
    for (int i = 0; i < glog.size() && i < 4; i++) begin
      check_eq("contend_id", glog[i].id, i % 2);
      if (i > 0) check_eq("contend_gap", glog[i].cyc - glog[i-1].cyc, 3);
    end

    // Backpressure: response held for several cycles, no grant while held.
    rsp_ready = 0;
    set_req(0, $urandom, $urandom, 4'd7);
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    step();
    check_eq("bp_valid", rsp_valid, 1'b1);
    snap_res   = rsp_result;
    snap_rem   = rsp_remainder;
    snap_flags = {rsp_carry, rsp_zero, rsp_overflow, rsp_err};
    repeat (5) begin
      step();
      check_eq("bp_hold_valid", rsp_valid, 1'b1);
      check_eq("bp_hold_ready", req_ready, 2'b00);
      check_eq("bp_hold_result", rsp_result, snap_res);
      check_eq("bp_hold_rem", rsp_remainder, snap_rem);
      check_eq("bp_hold_flags", {rsp_carry, rsp_zero, rsp_overflow, rsp_err}, snap_flags);
    end
    rsp_ready = 1;
    req_valid = 2'b00;
    @(negedge clk);
    check_eq("bp_last_valid", rsp_valid, 1'b1);
    step();
    check_eq("bp_done_valid", rsp_valid, 1'b0);

    // Illegal opcode from requester 1.
    set_req(1, 32'd123, 32'd456, 4'b1100);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    wait_rsp(lat);
    check_eq("illegal_err", rsp_err, 1'b1);
    check_eq("illegal_result", rsp_result, 32'd0);
    check_eq("illegal_id", rsp_id, 1'b1);
    step();

    // Reset while in EXEC discards the transaction and the pointer.
    set_req(0, 32'd1, 32'd2, 4'd0);
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    rst = 1;
    #1;
    check_eq("async_rst_busy", busy, 1'b0);
    check_eq("async_rst_valid", rsp_valid, 1'b0);
    check_eq("async_rst_ready", req_ready, 2'b00);
    step();
    glog.delete();
    rst = 0;
    step();
    req_valid = 2'b00;
    check_eq("post_rst_grants", glog.size(), 1);
    if (glog.size() > 0) check_eq("post_rst_id", glog[0].id, 1'b0);
    wait_rsp(lat);
    step();

    // Zero flag from subtract.
    set_req(0, 32'd5, 32'd5, 4'd1);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    wait_rsp(lat);
    check_eq("zero_result", rsp_result, 32'd0);
    check_eq("zero_flag", rsp_zero, 1'b1);
    check_eq("zero_err", rsp_err, 1'b0);
    step();

    // Random traffic, backpressure and occasional resets.
    for (int c = 0; c < 600; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) set_req(i, rand_operand(), rand_operand(), 4'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 0; req_valid = 2'b00; rsp_ready = 1;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
